sram_sp_bist_target: RTL and testbench

Parametrised single-port SRAM model that serves as the memory under test for the BIST controller. It generalises the fixed 256x4 array with configurable word width, depth and read latency. It adds a hardware initialisation sweep and a programmable stuck-at fault-injection table, so the BIST engine can be exercised against known defects at run time.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_fault_table.sv | 59 +++++
 rtl/sram_sp_bist_target.sv | 178 +++++++++++++++++
 tb/tb_sram_sp_bist_target.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults, FSM encoding and fault-entry layout for the single-port BIST target SRAM.
package sram_pkg;

    localparam int DEF_WORD_W     = 4;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_READ_LAT   = 1;
    localparam int DEF_NUM_FAULTS = 4;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    // Entry layout at the default widths; the fault table re-declares it at instance widths.
    typedef struct packed {
        logic                  en;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_WORD_W-1:0] sa0;
        logic [DEF_WORD_W-1:0] sa1;
    } flt_entry_t;

    function automatic int flt_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_fault_table.sv
// Programmable stuck-at fault table: NUM_FAULTS entries, combinational address match
// producing OR-ed stuck-at-0 / stuck-at-1 masks for the looked-up address.
module sram_fault_table
    import sram_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int IDX_W      = flt_idx_w(NUM_FAULTS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] sa0_i,
    input  logic [WORD_W-1:0] sa1_i,
    input  logic [ADDR_W-1:0] lkp_addr_i,
    output logic [WORD_W-1:0] sa0_o,
    output logic [WORD_W-1:0] sa1_o
);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] sa0;
        logic [WORD_W-1:0] sa1;
    } entry_t;

    entry_t tbl_q [NUM_FAULTS];

    // Indices beyond NUM_FAULTS-1 (non power-of-two tables) match no entry and are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_i) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (idx_i == IDX_W'(i)) begin
                    tbl_q[i] <= '{en: en_i, addr: addr_i, sa0: sa0_i, sa1: sa1_i};
                end
            end
        end
    end

    always_comb begin
        sa0_o = '0;
        sa1_o = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (tbl_q[i].en && (tbl_q[i].addr == lkp_addr_i)) begin
                sa0_o = sa0_o | tbl_q[i].sa0;
                sa1_o = sa1_o | tbl_q[i].sa1;
            end
        end
    end

endmodule

// File: rtl/sram_sp_bist_target.sv
// Single-port SRAM under test for the BIST engine: init sweep, stuck-at fault masking
// on reads, and a 1- or 2-cycle read pipeline.
//   state   | meaning
//   S_INIT  | sweeping INIT_VAL through every word, accesses ignored, busy=1
//   S_READY | serving req reads/writes, init_start restarts the sweep
module sram_sp_bist_target
    import sram_pkg::*;
#(
    parameter int              WORD_W     = DEF_WORD_W,
    parameter int              ADDR_W     = DEF_ADDR_W,
    parameter int              READ_LAT   = DEF_READ_LAT,
    parameter int              NUM_FAULTS = DEF_NUM_FAULTS,
    parameter logic [WORD_W-1:0] INIT_VAL = '0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 init_start_i,
    output logic                                 busy_o,
    input  logic                                 req_i,
    input  logic                                 we_i,
    input  logic [ADDR_W-1:0]                    addr_i,
    input  logic [WORD_W-1:0]                    data_in_i,
    output logic [WORD_W-1:0]                    data_out_o,
    output logic                                 rd_valid_o,
    input  logic                                 flt_wr_i,
    input  logic [flt_idx_w(NUM_FAULTS)-1:0]     flt_idx_i,
    input  logic                                 flt_en_i,
    input  logic [ADDR_W-1:0]                    flt_addr_i,
    input  logic [WORD_W-1:0]                    flt_sa0_i,
    input  logic [WORD_W-1:0]                    flt_sa1_i
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              acc_ok;
    logic              rd_issue;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [WORD_W-1:0] sa0_mask, sa1_mask;
    logic [WORD_W-1:0] rd_masked;

    logic              s0_vld_q;
    logic [WORD_W-1:0] s0_data_q;
    logic              last_vld;
    logic [WORD_W-1:0] last_data;
    logic              rd_valid_q;
    logic [WORD_W-1:0] data_out_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) begin
                state_d = S_READY;
            end
        end else if (init_start_i) begin
            state_d = S_INIT;
            cnt_d   = '0;
        end
    end

    assign busy_o   = (state_q == S_INIT);
    assign acc_ok   = (state_q == S_READY) && req_i && !init_start_i;
    assign rd_issue = acc_ok && !we_i;

    // The sweep owns the single port while in S_INIT; nothing is written during reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr_i;
        wr_data = data_in_i;
        if (!rst_i) begin
            if (state_q == S_INIT) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = INIT_VAL;
            end else if (acc_ok && we_i) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    sram_fault_table #(
        .WORD_W     (WORD_W),
        .ADDR_W     (ADDR_W),
        .NUM_FAULTS (NUM_FAULTS)
    ) u_fault_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_i       (flt_wr_i),
        .idx_i      (flt_idx_i),
        .en_i       (flt_en_i),
        .addr_i     (flt_addr_i),
        .sa0_i      (flt_sa0_i),
        .sa1_i      (flt_sa1_i),
        .lkp_addr_i (addr_i),
        .sa0_o      (sa0_mask),
        .sa1_o      (sa1_mask)
    );

    // SA1 is applied last so it wins over SA0 on overlapping bits.
    assign rd_masked = (mem_q[addr_i] & ~sa0_mask) | sa1_mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_vld_q  <= 1'b0;
            s0_data_q <= '0;
        end else begin
            s0_vld_q <= rd_issue;
            if (rd_issue) begin
                s0_data_q <= rd_masked;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s1_vld_q;
            logic [WORD_W-1:0] s1_data_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q <= s0_vld_q;
                    if (s0_vld_q) begin
                        s1_data_q <= s0_data_q;
                    end
                end
            end

            assign last_vld  = s1_vld_q;
            assign last_data = s1_data_q;
        end else begin : g_lat1
            assign last_vld  = s0_vld_q;
            assign last_data = s0_data_q;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            rd_valid_q <= last_vld;
            if (last_vld) begin
                data_out_q <= last_data;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign data_out_o = data_out_q;

endmodule

// File: tb/tb_sram_sp_bist_target.sv
// Directed bench for sram_sp_bist_target: one instance at read latency 1 and one at
// latency 2 share all stimulus; expected values are hand-computed per vector.
module tb_sram_sp_bist_target;

    logic       clk;
    logic       rst;
    logic       init_start;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [3:0] data_in;
    logic       flt_wr;
    logic [1:0] flt_idx;
    logic       flt_en;
    logic [7:0] flt_addr;
    logic [3:0] flt_sa0;
    logic [3:0] flt_sa1;

    logic       busy1, rv1;
    logic [3:0] dout1;
    logic       busy2, rv2;
    logic [3:0] dout2;

    int vec_cnt = 0;
    int err_cnt = 0;

    sram_sp_bist_target #(.READ_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .init_start_i(init_start), .busy_o(busy1),
        .req_i(req), .we_i(we), .addr_i(addr), .data_in_i(data_in),
        .data_out_o(dout1), .rd_valid_o(rv1),
        .flt_wr_i(flt_wr), .flt_idx_i(flt_idx), .flt_en_i(flt_en),
        .flt_addr_i(flt_addr), .flt_sa0_i(flt_sa0), .flt_sa1_i(flt_sa1)
    );

    sram_sp_bist_target #(.READ_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .init_start_i(init_start), .busy_o(busy2),
        .req_i(req), .we_i(we), .addr_i(addr), .data_in_i(data_in),
        .data_out_o(dout2), .rd_valid_o(rv2),
        .flt_wr_i(flt_wr), .flt_idx_i(flt_idx), .flt_en_i(flt_en),
        .flt_addr_i(flt_addr), .flt_sa0_i(flt_sa0), .flt_sa1_i(flt_sa1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] d);
        req = 1'b1; we = 1'b1; addr = a; data_in = d;
        step;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic set_flt(input logic [1:0] idx, input logic en, input logic [7:0] a,
                           input logic [3:0] s0, input logic [3:0] s1);
        flt_wr = 1'b1; flt_idx = idx; flt_en = en; flt_addr = a; flt_sa0 = s0; flt_sa1 = s1;
        step;
        flt_wr = 1'b0;
    endtask

    // Issues one read and checks both latencies cycle by cycle.
    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [3:0] exp);
        req = 1'b1; we = 1'b0; addr = a;
        step;
        req = 1'b0; flt_wr = 1'b0;
        chk({tag, "/issue"}, 32'({rv1, rv2}), 32'h0);
        step;
        chk({tag, "/lat1"}, 32'({rv1, dout1}), 32'({1'b1, exp}));
        chk({tag, "/lat2_early"}, 32'(rv2), 32'h0);
        step;
        chk({tag, "/lat1_pulse"}, 32'(rv1), 32'h0);
        chk({tag, "/lat2"}, 32'({rv2, dout2}), 32'({1'b1, exp}));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (busy1 && n < 400) begin
            step;
            n++;
        end
    endtask

    logic [7:0] seq_a [3];
    logic [3:0] seq_d [3];
    int n;
    int pulses;

    initial begin
        rst = 1'b1; init_start = 1'b0; req = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        flt_wr = 1'b0; flt_idx = '0; flt_en = 1'b0; flt_addr = '0; flt_sa0 = '0; flt_sa1 = '0;
        #1;
        chk("rst/busy", 32'({busy1, busy2}), 32'h3);
        chk("rst/rv", 32'({rv1, rv2}), 32'h0);
        chk("rst/dout", 32'({dout1, dout2}), 32'h0);
        step; step;
        rst = 1'b0;
        wait_ready(n);
        chk("init/cycles", 32'(n), 32'd256);
        chk("init/busy2", 32'(busy2), 32'h0);

        rd_chk("rd0", 8'h00, 4'h0);
        rd_chk("rd128", 8'h80, 4'h0);
        rd_chk("rd255", 8'hFF, 4'h0);

        wr(8'h10, 4'hA);
        rd_chk("wr_rd", 8'h10, 4'hA);

        set_flt(2'd0, 1'b1, 8'h0A, 4'h0, 4'h3);
        wr(8'h0A, 4'h4);
        wr(8'h0B, 4'h9);
        rd_chk("flt_sa1", 8'h0A, 4'h7);
        rd_chk("flt_other", 8'h0B, 4'h9);
        set_flt(2'd1, 1'b1, 8'h0A, 4'h4, 4'h0);
        rd_chk("flt_sa0", 8'h0A, 4'h3);
        set_flt(2'd2, 1'b1, 8'h0B, 4'h0, 4'h6);
        rd_chk("flt_next_cycle", 8'h0B, 4'hF);
        // Table write in the same cycle as the read: read must see the old table.
        flt_wr = 1'b1; flt_idx = 2'd3; flt_en = 1'b1; flt_addr = 8'h0B; flt_sa0 = 4'hF; flt_sa1 = 4'h0;
        rd_chk("flt_same_cycle", 8'h0B, 4'hF);
        rd_chk("flt_after", 8'h0B, 4'h6);

        seq_a[0] = 8'h0A; seq_a[1] = 8'h0B; seq_a[2] = 8'h10;
        seq_d[0] = 4'h3;  seq_d[1] = 4'h6;  seq_d[2] = 4'hA;
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) addr = seq_a[i];
            else req = 1'b0;
            step;
            if (i >= 1 && i <= 3) chk($sformatf("b2b/l1_%0d", i), 32'({rv1, dout1}), 32'({1'b1, seq_d[i-1]}));
            else chk($sformatf("b2b/l1_%0d", i), 32'(rv1), 32'h0);
            if (i >= 2) chk($sformatf("b2b/l2_%0d", i), 32'({rv2, dout2}), 32'({1'b1, seq_d[i-2]}));
            else chk($sformatf("b2b/l2_%0d", i), 32'(rv2), 32'h0);
        end

        wr(8'h03, 4'h5);
        req = 1'b1; we = 1'b0; addr = 8'h03;
        step;
        req = 1'b0; init_start = 1'b1;
        step;
        init_start = 1'b0;
        chk("reinit/inflight_l1", 32'({rv1, dout1}), 32'h15);
        chk("reinit/busy", 32'({busy1, busy2}), 32'h3);
        step;
        chk("reinit/inflight_l2", 32'({rv2, dout2}), 32'h15);
        n = 1;
        pulses = 0;
        req = 1'b1; we = 1'b0; addr = 8'h07;
        while (busy1 && n < 400) begin
            step;
            n++;
            if (rv1 || rv2) pulses++;
        end
        req = 1'b0;
        chk("reinit/cycles", 32'(n), 32'd256);
        chk("reinit/ignored_req", 32'(pulses), 32'd0);
        rd_chk("reinit/rd3", 8'h03, 4'h0);
        rd_chk("reinit/flt_kept", 8'h0A, 4'h3);

        wr(8'h0A, 4'hC);
        rd_chk("mask_c", 8'h0A, 4'hB);
        set_flt(2'd3, 1'b1, 8'h0A, 4'hF, 4'h0);
        rd_chk("sa1_wins", 8'h0A, 4'h3);

        req = 1'b1; we = 1'b0; addr = 8'h0A;
        step;
        addr = 8'h0B;
        step;
        chk("rst_mid/pre", 32'({rv1, dout1}), 32'h13);
        addr = 8'h10;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid/rv", 32'({rv1, rv2}), 32'h0);
        chk("rst_mid/busy", 32'({busy1, busy2}), 32'h3);
        chk("rst_mid/dout", 32'(dout1), 32'h0);
        addr = 8'h0A;
        step; step;
        chk("rst_mid/rv_hold", 32'({rv1, rv2}), 32'h0);
        req = 1'b0;
        rst = 1'b0;
        wait_ready(n);
        chk("rst_mid/cycles", 32'(n), 32'd256);
        rd_chk("rst_mid/flt_cleared", 8'h0A, 4'h0);
        rd_chk("rst_mid/flt_cleared_b", 8'h0B, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
